// File: rtl/shared_adder_arbiter.sv
// rtl/shared_adder_arbiter.sv - four requesters share one ripple adder through a round-robin grant
// The sum is registered into a single-entry valid/ready response stage.

module ripple_adder #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH:0]   sum
);
   logic [WIDTH-1:0] s;
   logic             carry;

   always_comb begin
      s     = '0;
      carry = cin;
      for (int i = 0; i < WIDTH; i++) begin
         s[i]  = a[i] ^ b[i] ^ carry;
         carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
   end

   assign sum = {carry, s};
endmodule

module shared_adder_arbiter #(
   parameter int WIDTH = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [3:0]         i_req_valid,
   input  logic [4*WIDTH-1:0] i_req_add1,
   input  logic [4*WIDTH-1:0] i_req_add2,
   output logic [3:0]         o_req_ready,
   output logic               o_rsp_valid,
   output logic [1:0]         o_rsp_id,
   output logic [WIDTH:0]     o_rsp_result,
   input  logic               i_rsp_ready
);
   logic [1:0]       rr_ptr;
   logic [1:0]       winner;
   logic [1:0]       idx;
   logic             found;
   logic             accept_ok;
   logic             accept;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH:0]   sum;

   // Scan starts at rr_ptr; the 2-bit add wraps the search order modulo 4.
   always_comb begin
      found  = 1'b0;
      winner = rr_ptr;
      idx    = '0;
      for (int i = 0; i < 4; i++) begin
         idx = rr_ptr + 2'(i);
         if (!found && i_req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign accept_ok   = i_rst_n & (~o_rsp_valid | i_rsp_ready);
   assign accept      = found & accept_ok;
   assign o_req_ready = accept ? (4'b0001 << winner) : 4'b0000;

   always_comb begin
      op_a = '0;
      op_b = '0;
      if (found) begin
         op_a = i_req_add1[winner*WIDTH +: WIDTH];
         op_b = i_req_add2[winner*WIDTH +: WIDTH];
      end
   end

   ripple_adder #(.WIDTH(WIDTH)) u_adder (
      .a   (op_a),
      .b   (op_b),
      .cin (1'b0),
      .sum (sum)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rr_ptr       <= '0;
         o_rsp_valid  <= 1'b0;
         o_rsp_id     <= '0;
         o_rsp_result <= '0;
      end else if (accept) begin
         rr_ptr       <= winner + 2'd1;
         o_rsp_valid  <= 1'b1;
         o_rsp_id     <= winner;
         o_rsp_result <= sum;
      end else if (o_rsp_valid && i_rsp_ready) begin
         o_rsp_valid  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_shared_adder_arbiter.sv
// tb/tb_shared_adder_arbiter.sv - directed and randomized checks of shared_adder_arbiter against a behavioural model

module tb_shared_adder_arbiter;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [3:0]     req_valid;
   logic [4*W-1:0] add1;
   logic [4*W-1:0] add2;
   logic [3:0]     req_ready;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [W:0]     rsp_result;
   logic           rsp_ready;

   int n_cmp = 0;
   int n_bad = 0;

   // model state: priority pointer and the single response slot
   int         m_ptr = 0;
   bit         m_valid = 0;
   int         m_id = 0;
   logic [W:0] m_result = '0;
   logic [3:0] acc_mask = '0;

   shared_adder_arbiter #(.WIDTH(W)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .i_req_add1   (add1),
      .i_req_add2   (add2),
      .o_req_ready  (req_ready),
      .o_rsp_valid  (rsp_valid),
      .o_rsp_id     (rsp_id),
      .o_rsp_result (rsp_result),
      .i_rsp_ready  (rsp_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
      add1[k*W +: W] = a;
      add2[k*W +: W] = b;
   endtask

   // Per-cycle compare at the falling edge, model advance at the rising edge.
   initial begin
      int         n_ptr, n_id, k;
      bit         n_valid, found;
      logic [W:0] n_result;
      logic [3:0] exp_ready;
      forever begin
         @(negedge clk);
         exp_ready = '0;
         found     = 0;
         k         = 0;
         if (rst_n && (!m_valid || rsp_ready)) begin
            for (int j = 0; j < 4; j++) begin
               if (!found && req_valid[(m_ptr + j) % 4]) begin
                  found = 1;
                  k     = (m_ptr + j) % 4;
               end
            end
         end
         if (found) exp_ready[k] = 1'b1;
         check("req_ready", 32'(req_ready), 32'(exp_ready));
         check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
         check("rsp_id", 32'(rsp_id), 32'(m_id));
         check("rsp_result", 32'(rsp_result), 32'(m_result));
         n_ptr = m_ptr; n_valid = m_valid; n_id = m_id; n_result = m_result;
         if (!rst_n) begin
            n_ptr = 0; n_valid = 0; n_id = 0; n_result = '0;
         end else if (found) begin
            n_valid  = 1;
            n_id     = k;
            n_result = {1'b0, add1[k*W +: W]} + {1'b0, add2[k*W +: W]};
            n_ptr    = (k + 1) % 4;
         end else if (m_valid && rsp_ready) begin
            n_valid = 0;
         end
         @(posedge clk);
         m_ptr = n_ptr; m_valid = n_valid; m_id = n_id; m_result = n_result;
         acc_mask = exp_ready;
      end
   end

   initial begin
      rst_n = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 4'hF;
      add1 = '0;
      add2 = '0;
      for (int k = 0; k < 4; k++) set_op(k, W'(k), W'(10 * k));
      #2 check("rst_ready0", 32'(req_ready), 32'h0);
      step(); #1 check("rst_ready1", 32'(req_ready), 32'h0);
      step(); rst_n = 1'b1; #1;
      check("post_rst_valid", 32'(rsp_valid), 32'h0);
      check("post_rst_result", 32'(rsp_result), 32'h0);

      // all four valid: grants rotate 0,1,2,3,... and each sum is 11*k
      for (int i = 0; i < 8; i++) begin
         check("rr_grant", 32'(req_ready), 32'(4'b0001 << (i % 4)));
         step();
         if (i >= 4) req_valid[i % 4] = 1'b0;
         #1;
         check("rr_id", 32'(rsp_id), 32'(i % 4));
         check("rr_result", 32'(rsp_result), 32'(11 * (i % 4)));
      end

      // single request with carry-out
      req_valid = 4'b0100; set_op(2, 16'hFFFF, 16'h0001); #1;
      check("single_ready", 32'(req_ready), 32'h4);
      step(); req_valid = 4'b0; #1;
      check("single_valid", 32'(rsp_valid), 32'h1);
      check("single_id", 32'(rsp_id), 32'h2);
      check("single_result", 32'(rsp_result), 32'h10000);

      // backpressure with requester 3 pending
      req_valid = 4'b0010; set_op(1, 16'd2, 16'd3); #1;
      check("bp_first_ready", 32'(req_ready), 32'h2);
      step(); req_valid = 4'b1000; set_op(3, 16'd7, 16'd8); rsp_ready = 1'b0; #1;
      for (int i = 0; i < 3; i++) begin
         check("bp_ready", 32'(req_ready), 32'h0);
         check("bp_id", 32'(rsp_id), 32'h1);
         check("bp_result", 32'(rsp_result), 32'h5);
         if (i < 2) step();
         #1;
      end
      step(); rsp_ready = 1'b1; #1;
      check("bp_release_ready", 32'(req_ready), 32'h8);
      step(); req_valid = 4'b0; #1;
      check("bp_new_id", 32'(rsp_id), 32'h3);
      check("bp_new_valid", 32'(rsp_valid), 32'h1);
      check("bp_new_result", 32'(rsp_result), 32'd15);

      // priority: after a grant to 1, 3 beats 0
      req_valid = 4'b0010; set_op(1, 16'd1, 16'd1); #1;
      check("prio_g1", 32'(req_ready), 32'h2);
      step(); req_valid = 4'b1001; set_op(0, 16'd4, 16'd4); set_op(3, 16'd5, 16'd5); #1;
      check("prio_g3", 32'(req_ready), 32'h8);
      step(); req_valid = 4'b0001; #1;
      check("prio_g0", 32'(req_ready), 32'h1);
      check("prio_id3", 32'(rsp_id), 32'h3);
      step(); req_valid = 4'b0; #1;
      check("prio_id0", 32'(rsp_id), 32'h0);
      check("prio_result0", 32'(rsp_result), 32'd8);
      check("prio_ptr", 32'(m_ptr), 32'h1);

      // reset with a held response and requesters 1 and 2 waiting
      rsp_ready = 1'b0; req_valid = 4'b0110;
      set_op(1, 16'd9, 16'd9); set_op(2, 16'd3, 16'd4); #1;
      check("mid_held_valid", 32'(rsp_valid), 32'h1);
      step(); rst_n = 1'b0; #1;
      check("mid_rst_ready", 32'(req_ready), 32'h0);
      step(); rst_n = 1'b1; rsp_ready = 1'b1; #1;
      check("mid_post_valid", 32'(rsp_valid), 32'h0);
      check("mid_post_grant", 32'(req_ready), 32'h2);
      step(); req_valid = 4'b0100; #1;
      check("mid_id1", 32'(rsp_id), 32'h1);
      check("mid_result1", 32'(rsp_result), 32'd18);
      step(); req_valid = 4'b0; #1;
      check("mid_id2", 32'(rsp_id), 32'h2);

      // random traffic obeying the hold-until-accepted rule
      for (int c = 0; c < 3000; c++) begin
         step();
         for (int k = 0; k < 4; k++) begin
            if (req_valid[k] && acc_mask[k]) req_valid[k] = 1'b0;
            if (!req_valid[k] && ($urandom_range(0, 2) == 0)) begin
               req_valid[k] = 1'b1;
               set_op(k, W'($urandom), W'($urandom));
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         rst_n = ($urandom_range(0, 149) != 0);
      end
      step(); rst_n = 1'b1; req_valid = '0;
      step(); step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/shared_adder_arbiter.md
# shared_adder_arbiter

Shares one `ripple_adder` instance (WIDTH-bit operands, WIDTH+1-bit result) among four requesters. Each cycle a round-robin arbiter grants at most one valid requester and feeds its operands to the adder. The sum is registered into a single-entry response stage with a valid/ready handshake. The block sits between the multiplier's partial-product producers and the shared adder, so one adder serves several stages.

## Interface
- WIDTH, 16, operand width; the adder is instantiated with this WIDTH
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_req_valid  in  4  per-requester request valid; bit k = requester k
- i_req_add1  in  4*WIDTH  operand 1; requester k at [k*WIDTH +: WIDTH]
- i_req_add2  in  4*WIDTH  operand 2; same packing
- o_req_ready  out  4  one-hot (or zero) grant; request k is accepted on an edge where i_req_valid[k] and o_req_ready[k] are both 1
- o_rsp_valid  out  1  response register holds a result
- o_rsp_id  out  2  index of the requester that owns the response
- o_rsp_result  out  WIDTH+1  unsigned sum, including the carry-out in the MSB
- i_rsp_ready  in  1  consumer accepts the response on an edge where o_rsp_valid is 1

## Operation
- State:
  - rr_ptr (2 bits): highest-priority requester index.
  - Response register: o_rsp_valid, o_rsp_id, o_rsp_result.
- accept_ok = i_rst_n & (~o_rsp_valid | i_rsp_ready).
- Arbitration is combinational. The winner is the first k with i_req_valid[k]=1, scanning k = rr_ptr, rr_ptr+1, … mod 4.
- o_req_ready[winner] = accept_ok. All other bits are 0. If no request is valid, o_req_ready = 0.
- o_req_ready may depend combinationally on i_req_valid and i_rsp_ready. Requesters must not make i_req_valid depend on o_req_ready.
- The adder inputs are the winner's operands. When there is no winner the inputs are zeros; the adder output is don't-care.
- On an accept edge:
  - o_rsp_result <= adder result (WIDTH+1 bits, the carry-in is always 0).
  - o_rsp_id <= winner.
  - o_rsp_valid <= 1.
  - rr_ptr <= winner + 1 mod 4.
- On a drain with no accept (o_rsp_valid & i_rsp_ready, and no winner): o_rsp_valid <= 0. o_rsp_id and o_rsp_result keep their old values.
- On an edge with neither accept nor drain: all state holds.
- Requester protocol: once i_req_valid[k] is raised, it stays high and the operands stay stable until accepted. The block does not check this.
- Fairness: a requester that holds i_req_valid high is granted within at most 4 accepts.

## Timing
- Reset (i_rst_n=0 at an edge) sets o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0 and rr_ptr=0.
- While i_rst_n=0, o_req_ready=0.
- Reset mid-operation discards any pending response without delivering it. A requester that was waiting is not accepted during reset and must keep its request asserted.
- Latency: the response is visible with o_rsp_valid=1 in the cycle after the accept edge.
- Throughput: one accept per cycle while i_rsp_ready=1.
- Simultaneous drain and accept on one edge: the old response is consumed and the new one is loaded. There is no bubble and no loss.
- Backpressure: while o_rsp_valid=1 and i_rsp_ready=0:
  - o_req_ready = 0.
  - o_rsp_id and o_rsp_result are held stable.
  - rr_ptr is unchanged.
- rr_ptr wraps from 3 to 0.
- rr_ptr changes only on accept edges. Idle cycles do not rotate priority.
- Overflow: the full WIDTH+1-bit result is returned with no truncation.

## Test plan
- Reset with i_req_valid=4'b1111 and i_rst_n=0 for 2 cycles:
  - o_req_ready=0 throughout.
  - After release, o_rsp_valid=0 and o_rsp_result=0.
  - The first grant goes to requester 0.
- Single request from requester 2 only, add1=16'hFFFF, add2=16'h0001, i_rsp_ready=1:
  - o_req_ready=4'b0100 in the request cycle.
  - Next cycle: o_rsp_valid=1, o_rsp_id=2, o_rsp_result=17'h10000.
- All four requesters valid continuously (operands k and 10*k), i_rsp_ready=1:
  - Grants go 0,1,2,3,0 on consecutive cycles.
  - Results are 0, 11, 22, 33, 0, with matching o_rsp_id.
- Backpressure: hold i_rsp_ready=0 for 3 cycles while the response is id=1, result=17'h00005, with requester 3 pending:
  - During the 3 cycles, o_req_ready=0 and the response is unchanged.
  - On release, requester 3 is accepted on the same edge the old response drains.
  - Next cycle: o_rsp_id=3 and o_rsp_valid stays 1.
- Round-robin priority: after a grant to 1 (rr_ptr=2), requesters 0 and 3 are valid together:
  - 3 is granted first, then 0.
  - After that, rr_ptr=1.
- Reset mid-operation with o_rsp_valid=1 and requesters 1 and 2 pending:
  - After reset, o_rsp_valid=0 and the pending response is never delivered.
  - rr_ptr=0, so the first grant after reset goes to 1.
